// File: rtl/aclk_fsm_if.sv
// Keypad/button inputs and display/load strobes of the alarm-clock control FSM.
interface aclk_fsm_if;
    logic [3:0] key;
    logic       alarm_button;
    logic       time_button;
    logic       one_second;
    logic       shift;
    logic       show_new_time;
    logic       show_a;
    logic       load_new_a;
    logic       load_new_c;
    logic       reset_count;

    // Driver side: keypad decoder, buttons and timing generator
    modport master (
        output key, alarm_button, time_button, one_second,
        input  shift, show_new_time, show_a, load_new_a, load_new_c, reset_count
    );

    // Controller side
    modport slave (
        input  key, alarm_button, time_button, one_second,
        output shift, show_new_time, show_a, load_new_a, load_new_c, reset_count
    );
endinterface

// File: rtl/aclk_fsm.sv
// Alarm-clock main control FSM: key entry, alarm/time commit and idle timeout.
module aclk_fsm #(
    parameter logic [3:0]  NOKEY       = 4'd10,
    parameter int unsigned TIMEOUT_SEC = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clock,
    input  logic        reset,
    aclk_fsm_if.slave   bus
);

    localparam int unsigned STATE_W = 3;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_SEC);

    typedef enum logic [STATE_W-1:0] {
        SHOW_TIME        = 3'd0,
        KEY_STORED       = 3'd1,
        KEY_WAITED       = 3'd2,
        KEY_ENTRY        = 3'd3,
        SHOW_ALARM       = 3'd4,
        SET_ALARM_TIME   = 3'd5,
        SET_CURRENT_TIME = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic             time_out_c;
    logic             in_entry_c;

    // Output registers hold the decode of the current state
    logic shift_q, show_new_time_q, show_a_q, load_new_a_q, load_new_c_q, reset_count_q;
    logic shift_nxt, show_new_time_nxt, show_a_nxt, load_new_a_nxt, load_new_c_nxt, reset_count_nxt;

    assign time_out_c = (count == TIMEOUT_VAL);
    assign in_entry_c = (state == KEY_WAITED) || (state == KEY_ENTRY);

    // State register and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= SHOW_TIME;
            shift_q         <= 1'b0;
            show_new_time_q <= 1'b0;
            show_a_q        <= 1'b0;
            load_new_a_q    <= 1'b0;
            load_new_c_q    <= 1'b0;
            reset_count_q   <= 1'b0;
        end else begin
            state           <= state_nxt;
            shift_q         <= shift_nxt;
            show_new_time_q <= show_new_time_nxt;
            show_a_q        <= show_a_nxt;
            load_new_a_q    <= load_new_a_nxt;
            load_new_c_q    <= load_new_c_nxt;
            reset_count_q   <= reset_count_nxt;
        end
    end

    // Idle-seconds counter: runs only while awaiting further keys, saturates at the limit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (in_entry_c) begin
            if (bus.one_second && !time_out_c) begin
                count <= count + CNT_W'(1);
            end
        end else begin
            count <= '0;
        end
    end

    // Next-state logic; buttons outrank keys, keys outrank timeout
    always_comb begin
        state_nxt = state;
        case (state)
            SHOW_TIME: begin
                if (bus.alarm_button)      state_nxt = SHOW_ALARM;
                else if (bus.key != NOKEY) state_nxt = KEY_STORED;
            end
            KEY_STORED: state_nxt = KEY_WAITED;
            KEY_WAITED: begin
                if (bus.key == NOKEY)  state_nxt = KEY_ENTRY;
                else if (time_out_c)   state_nxt = SHOW_TIME;
            end
            KEY_ENTRY: begin
                if (bus.alarm_button)      state_nxt = SET_ALARM_TIME;
                else if (bus.time_button)  state_nxt = SET_CURRENT_TIME;
                else if (bus.key != NOKEY) state_nxt = KEY_STORED;
                else if (time_out_c)       state_nxt = SHOW_TIME;
            end
            SHOW_ALARM: begin
                if (!bus.alarm_button) state_nxt = SHOW_TIME;
            end
            SET_ALARM_TIME:   state_nxt = SHOW_TIME;
            SET_CURRENT_TIME: state_nxt = SHOW_TIME;
            default:          state_nxt = SHOW_TIME;
        endcase
    end

    // Output decode of the state being entered, so registered outputs track the state
    always_comb begin
        shift_nxt         = 1'b0;
        show_new_time_nxt = 1'b0;
        show_a_nxt        = 1'b0;
        load_new_a_nxt    = 1'b0;
        load_new_c_nxt    = 1'b0;
        reset_count_nxt   = 1'b0;
        case (state_nxt)
            KEY_STORED: begin
                shift_nxt         = 1'b1;
                show_new_time_nxt = 1'b1;
            end
            KEY_WAITED:       show_new_time_nxt = 1'b1;
            KEY_ENTRY:        show_new_time_nxt = 1'b1;
            SHOW_ALARM:       show_a_nxt        = 1'b1;
            SET_ALARM_TIME:   load_new_a_nxt    = 1'b1;
            SET_CURRENT_TIME: begin
                load_new_c_nxt  = 1'b1;
                reset_count_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.shift         = shift_q;
    assign bus.show_new_time = show_new_time_q;
    assign bus.show_a        = show_a_q;
    assign bus.load_new_a    = load_new_a_q;
    assign bus.load_new_c    = load_new_c_q;
    assign bus.reset_count   = reset_count_q;

endmodule
